sram_bus_arbiter: RTL

Sequences 32-bit word accesses from the CPU's instruction-fetch and data ports onto the 16-bit external asynchronous SRAM (1M x 16), splitting each word into two halfword phases. It replaces the ad-hoc clock-halving memory glue in the top level: it runs on the full-rate clock, arbitrates round-robin between the two requesters, and drives the SRAM strobes directly. The top level only owns the tristate buffer (`dq_oe` selects `dq_out` onto the pad).

---
 rtl/sram_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Round-robin arbiter that maps 32-bit instruction-fetch and data accesses
// onto a 16-bit asynchronous SRAM (1M x 16) as two halfword phases (high
// half [31:16] at even halfword address, low half [15:0] at odd).
//
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   i_req/i_addr          instruction read request (held until i_ready)
//   i_ready, i_rvalid     accept pulse (combinational), fetched-word pulse
//   d_req/d_we/d_be       data request, write flag, byte enables
//   d_addr/d_wdata        data byte address, write data
//   d_ready, d_rvalid     accept pulse (combinational), done pulse
//   rdata                 read data shared by both ports
//   sram_adr              halfword address to the SRAM
//   dq_in/dq_out/dq_oe    SRAM data pad in / out / output enable
//   ce_n,oe_n,we_n,ub_n,lb_n  SRAM strobes, active-low
module sram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic [19:0] sram_adr,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        ub_n,
    output logic        lb_n
);

    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned WA_W  = 19;

    localparam logic [ST_W-1:0] S_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] S_HI_SETUP = 3'd1;
    localparam logic [ST_W-1:0] S_HI_ACT   = 3'd2;
    localparam logic [ST_W-1:0] S_LO_SETUP = 3'd3;
    localparam logic [ST_W-1:0] S_LO_ACT   = 3'd4;
    localparam logic [ST_W-1:0] S_RESP     = 3'd5;

    logic [ST_W-1:0]  state, state_next;
    logic             run_q;
    logic             last_i_q;
    logic             own_d_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [WA_W-1:0]  wadr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] wcnt_q;

    logic             act_done;
    logic             grant_d;
    logic             accept;
    logic             cur_own_d;
    logic             cur_we;
    logic [3:0]       cur_be;
    logic [WA_W-1:0]  cur_wadr;
    logic [31:0]      cur_wdata;

    logic             ce_n_nx, oe_n_nx, we_n_nx, ub_n_nx, lb_n_nx, dq_oe_nx;
    logic             i_rv_nx, d_rv_nx;
    logic [19:0]      adr_nx;
    logic [15:0]      dq_out_nx;

    // Byte-lane and high address bits are not part of the halfword address.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, i_addr[31:21], i_addr[1:0],
                                d_addr[31:21], d_addr[1:0]};

    // Round-robin: data wins unless instruction is also asking and data went last.
    assign act_done = (wcnt_q == CNT_W'(WAIT_CYCLES));
    assign grant_d  = d_req && (!i_req || last_i_q);
    assign accept   = (state == S_IDLE) && run_q && (d_req || i_req);
    assign d_ready  = accept && grant_d;
    assign i_ready  = accept && !grant_d;

    // Transaction attributes: live inputs in the accept cycle, latched afterwards.
    assign cur_own_d = accept ? grant_d : own_d_q;
    assign cur_we    = accept ? (grant_d && d_we) : we_q;
    assign cur_be    = accept ? d_be : be_q;
    assign cur_wadr  = accept ? (grant_d ? d_addr[20:2] : i_addr[20:2]) : wadr_q;
    assign cur_wdata = accept ? d_wdata : wdata_q;

    // Next state and next registered outputs.
    always_comb begin
        state_next = state;
        ce_n_nx    = 1'b1;
        oe_n_nx    = 1'b1;
        we_n_nx    = 1'b1;
        ub_n_nx    = 1'b1;
        lb_n_nx    = 1'b1;
        dq_oe_nx   = 1'b0;
        i_rv_nx    = 1'b0;
        d_rv_nx    = 1'b0;
        adr_nx     = sram_adr;
        dq_out_nx  = dq_out;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    // Writes skip any halfword phase with no enabled bytes.
                    if (!cur_we || (|cur_be[3:2])) begin
                        state_next = S_HI_SETUP;
                    end else if (|cur_be[1:0]) begin
                        state_next = S_LO_SETUP;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_HI_SETUP: state_next = S_HI_ACT;
            S_HI_ACT: begin
                if (act_done) begin
                    state_next = (!we_q || (|be_q[1:0])) ? S_LO_SETUP : S_RESP;
                end
            end
            S_LO_SETUP: state_next = S_LO_ACT;
            S_LO_ACT: begin
                if (act_done) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_HI_SETUP, S_LO_SETUP: begin
                ce_n_nx = 1'b0;
                adr_nx  = {cur_wadr, (state_next == S_LO_SETUP)};
                if (cur_we) begin
                    dq_oe_nx  = 1'b1;
                    dq_out_nx = (state_next == S_LO_SETUP) ? cur_wdata[15:0]
                                                           : cur_wdata[31:16];
                end
            end
            S_HI_ACT, S_LO_ACT: begin
                ce_n_nx = 1'b0;
                if (cur_we) begin
                    we_n_nx  = 1'b0;
                    dq_oe_nx = 1'b1;
                    {ub_n_nx, lb_n_nx} = (state_next == S_LO_ACT) ? ~cur_be[1:0]
                                                                  : ~cur_be[3:2];
                end else begin
                    oe_n_nx = 1'b0;
                    ub_n_nx = 1'b0;
                    lb_n_nx = 1'b0;
                end
            end
            S_RESP: begin
                d_rv_nx = cur_own_d;
                i_rv_nx = !cur_own_d;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are enabled one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Transaction latches and arbitration pointer (reset favours data).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_i_q <= 1'b1;
            own_d_q  <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wadr_q   <= '0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            last_i_q <= !grant_d;
            own_d_q  <= grant_d;
            we_q     <= cur_we;
            be_q     <= cur_be;
            wadr_q   <= cur_wadr;
            wdata_q  <= cur_wdata;
        end
    end

    // Active-strobe stretch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
        end else if (((state == S_HI_ACT) || (state == S_LO_ACT)) && !act_done) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
        end else begin
            wcnt_q <= '0;
        end
    end

    // Read capture on the last active cycle of each read phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'h0;
        end else if (act_done && !we_q) begin
            if (state == S_HI_ACT) begin
                rdata[31:16] <= dq_in;
            end else if (state == S_LO_ACT) begin
                rdata[15:0] <= dq_in;
            end
        end
    end

    // Registered SRAM and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            ub_n     <= 1'b1;
            lb_n     <= 1'b1;
            dq_oe    <= 1'b0;
            sram_adr <= 20'h0;
            dq_out   <= 16'h0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            ce_n     <= ce_n_nx;
            oe_n     <= oe_n_nx;
            we_n     <= we_n_nx;
            ub_n     <= ub_n_nx;
            lb_n     <= lb_n_nx;
            dq_oe    <= dq_oe_nx;
            sram_adr <= adr_nx;
            dq_out   <= dq_out_nx;
            i_rvalid <= i_rv_nx;
            d_rvalid <= d_rv_nx;
        end
    end

endmodule
